// File: rtl/key_event_scheduler.sv
// key_event_scheduler: synchronizes and debounces keys, then queues press events round-robin into a FIFO.
// Define KEY_SCHED_RELEASE_EN to also queue release events (evt_release=1).
module key_event_scheduler #(
    parameter int NUM_KEYS        = 4,
    parameter int SYNC_DEPTH      = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_KEYS-1:0]         key_raw,
    output logic [NUM_KEYS-1:0]         key_level,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [$clog2(NUM_KEYS)-1:0] evt_id,
    output logic                        evt_release,
    output logic                        overflow
);
    localparam int IDW = $clog2(NUM_KEYS);
    localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW  = $clog2(FIFO_DEPTH);
`ifdef KEY_SCHED_RELEASE_EN
    localparam int EW  = IDW + 1;
`else
    localparam int EW  = IDW;
`endif
    logic [SYNC_DEPTH-1:0] sync [NUM_KEYS];
    logic [CW-1:0]         cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0]   level_d, rise, pend_press, req, gnt_oh, clr_press, lost;
    logic [IDW-1:0]        rr_ptr, gnt_key, idx;
    logic                  found, push, pop, full;
    logic [EW-1:0]         mem [FIFO_DEPTH];
    logic [EW-1:0]         wdata;
    logic [PW-1:0]         wptr, rptr;
    logic [PW:0]           count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                sync[i] <= '0;
                cnt[i]  <= '0;
            end
            key_level <= '0;
            level_d   <= '0;
        end else begin
            level_d <= key_level;
            for (int i = 0; i < NUM_KEYS; i++) begin
                sync[i]      <= {sync[i][SYNC_DEPTH-2:0], key_raw[i]};
                cnt[i]       <= (sync[i][SYNC_DEPTH-1] == key_level[i] || cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) ? '0 : cnt[i] + 1'b1;
                key_level[i] <= (sync[i][SYNC_DEPTH-1] != key_level[i] && cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) ? sync[i][SYNC_DEPTH-1] : key_level[i];
            end
        end
    end

    assign rise = key_level & ~level_d;
`ifdef KEY_SCHED_RELEASE_EN
    logic [NUM_KEYS-1:0] fall, pend_rel, clr_rel;
    logic                gnt_rel;
    assign fall      = ~key_level & level_d;
    assign req       = pend_press | pend_rel;
    assign clr_press = gnt_rel ? '0 : gnt_oh;
    assign clr_rel   = gnt_rel ? gnt_oh : '0;
    assign lost      = (rise & pend_press) | (fall & pend_rel);
    assign wdata     = {gnt_rel, gnt_key};
    assign evt_release = evt_valid & mem[rptr][IDW];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pend_rel <= '0;
        else
            pend_rel <= (pend_rel & ~clr_rel) | (fall & ~pend_rel);
    end
`else
    assign req       = pend_press;
    assign clr_press = gnt_oh;
    assign lost      = rise & pend_press;
    assign wdata     = gnt_key;
    assign evt_release = 1'b0;
`endif

    // First requesting key at or after rr_ptr wins; press outranks release of the same key.
    always_comb begin
        found   = 1'b0;
        gnt_key = '0;
        idx     = '0;
`ifdef KEY_SCHED_RELEASE_EN
        gnt_rel = 1'b0;
`endif
        for (int j = 0; j < NUM_KEYS; j++) begin
            idx = IDW'((int'(rr_ptr) + j) % NUM_KEYS);
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_key = idx;
`ifdef KEY_SCHED_RELEASE_EN
                gnt_rel = !pend_press[idx];
`endif
            end
        end
    end

    assign full   = count == (PW+1)'(FIFO_DEPTH);
    assign pop    = evt_valid && evt_ready;
    assign push   = found && (!full || pop);
    assign gnt_oh = push ? NUM_KEYS'(1) << gnt_key : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_press <= '0;
            rr_ptr     <= '0;
            overflow   <= 1'b0;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
        end else begin
            pend_press <= (pend_press & ~clr_press) | (rise & ~pend_press);
            overflow   <= overflow | (|lost);
            rr_ptr     <= push ? ((gnt_key == IDW'(NUM_KEYS - 1)) ? '0 : gnt_key + 1'b1) : rr_ptr;
            wptr       <= wptr + PW'(push);
            rptr       <= rptr + PW'(pop);
            count      <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= wdata;
    end

    assign evt_valid = count != '0;
    assign evt_id    = evt_valid ? mem[rptr][IDW-1:0] : '0;
endmodule

// File: tb/tb_key_event_scheduler.sv
// tb_key_event_scheduler: directed scenarios for key_event_scheduler checked against a queue-based model.
// Honors KEY_SCHED_RELEASE_EN the same way as the design.
module tb_key_event_scheduler;
    localparam int NK = 4;
    localparam int SD = 4;
    localparam int DC = 8;
    localparam int FD = 4;

    logic          clk, reset, evt_valid, evt_ready, evt_release, overflow;
    logic [NK-1:0] key_raw, key_level;
    logic [1:0]    evt_id;

    key_event_scheduler #(.NUM_KEYS(NK), .SYNC_DEPTH(SD), .DEBOUNCE_CYCLES(DC), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset), .key_raw(key_raw), .key_level(key_level),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
        .evt_release(evt_release), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp, n_bad, cyc;
    int got[$], gotc[$];
    bit seen_v, seen_l;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: events are id + 8*release; queue holds them in push order.
    logic [NK-1:0] raw_q[$];
    logic [NK-1:0] m_lvl, m_pp, m_pr, m_tp, m_tr;
    int            m_run[NK];
    int            m_rr, m_q[$];
    bit            m_ovf;

    function automatic void model_clear();
        raw_q.delete();
        m_q.delete();
        m_lvl = '0; m_pp = '0; m_pr = '0; m_tp = '0; m_tr = '0;
        m_rr = 0; m_ovf = 1'b0;
        foreach (m_run[i]) m_run[i] = 0;
    endfunction

    function automatic void model_step();
        logic [NK-1:0] s, pp0, pr0;
        int g;
        bit grel;
        s = (raw_q.size() == SD) ? raw_q[0] : '0;
        raw_q.push_back(key_raw);
        if (raw_q.size() > SD) void'(raw_q.pop_front());
        pp0 = m_pp;
        pr0 = m_pr;
        if (m_q.size() > 0 && evt_ready) void'(m_q.pop_front());
        g = -1;
        grel = 1'b0;
        for (int j = 0; j < NK && g < 0; j++) begin
            int k = (m_rr + j) % NK;
            if (pp0[k]) g = k;
            else if (pr0[k]) begin g = k; grel = 1'b1; end
        end
        if (g >= 0 && m_q.size() < FD) begin
            m_q.push_back(g + (grel ? 8 : 0));
            if (grel) m_pr[g] = 1'b0; else m_pp[g] = 1'b0;
            m_rr = (g + 1) % NK;
        end
        for (int i = 0; i < NK; i++) begin
            if (m_tp[i]) begin if (pp0[i]) m_ovf = 1'b1; else m_pp[i] = 1'b1; end
`ifdef KEY_SCHED_RELEASE_EN
            if (m_tr[i]) begin if (pr0[i]) m_ovf = 1'b1; else m_pr[i] = 1'b1; end
`endif
        end
        m_tp = '0;
        m_tr = '0;
        for (int i = 0; i < NK; i++) begin
            if (s[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DC) begin
                    m_lvl[i] = s[i];
                    m_run[i] = 0;
                    if (s[i]) m_tp[i] = 1'b1; else m_tr[i] = 1'b1;
                end
            end else m_run[i] = 0;
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!reset) model_clear();
        else model_step();
    end

    always @(negedge clk) begin
        #1;
        if (!reset) model_clear();
        chk("key_level", key_level, m_lvl);
        chk("evt_valid", evt_valid, m_q.size() > 0);
        chk("evt_id", evt_id, m_q.size() > 0 ? m_q[0] % 8 : 0);
        chk("evt_release", evt_release, m_q.size() > 0 ? m_q[0] / 8 : 0);
        chk("overflow", overflow, m_ovf);
        if (reset && evt_valid && evt_ready) begin
            got.push_back(int'(evt_id) + (evt_release ? 8 : 0));
            gotc.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        got.delete();
        gotc.delete();
    endtask

    task automatic expect_seq(input string name, input int n, input bit consec,
                              input int e0 = 0, input int e1 = 0, input int e2 = 0, input int e3 = 0, input int e4 = 0);
        int e[5];
        e = '{e0, e1, e2, e3, e4};
        chk({name, "_len"}, got.size(), n);
        for (int j = 0; j < n; j++) begin
            chk(name, j < got.size() ? got[j] : -1, e[j]);
            if (consec && j > 0 && j < gotc.size()) chk({name, "_gap"}, gotc[j] - gotc[j-1], 1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        key_raw = '0; evt_ready = 1'b0; reset = 1'b0;
        tick(2);
        chk("rst_valid", evt_valid, 0);
        chk("rst_id", evt_id, 0);
        chk("rst_release", evt_release, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_level", key_level, 0);
        reset = 1'b1;
        // Single press latency on key 2
        key_raw = 4'b0100;
        for (int e = 1; e <= 14; e++) begin
            tick(1);
            if (e == 11) chk("lvl2_e11", key_level[2], 0);
            if (e == 12) chk("lvl2_e12", key_level[2], 1);
            if (e == 13) chk("valid_e13", evt_valid, 0);
            if (e == 14) begin
                chk("valid_e14", evt_valid, 1);
                chk("id_e14", evt_id, 2);
            end
        end
        // Short glitch on key 1
        key_raw = '0;
        do_reset();
        key_raw = 4'b0010;
        tick(5);
        key_raw = '0;
        seen_v = 1'b0; seen_l = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick(1);
            seen_v |= evt_valid;
            seen_l |= |key_level;
        end
        chk("glitch_valid", seen_v, 0);
        chk("glitch_level", seen_l, 0);
        // Round robin: all keys together, then keys 0 and 3
        do_reset();
        evt_ready = 1'b1;
        key_raw = 4'b1111;
        tick(30);
        expect_seq("rr_all", 4, 1'b1, 0, 1, 2, 3);
        key_raw = '0;
        tick(30);
        got.delete();
        gotc.delete();
        key_raw = 4'b1001;
        tick(30);
        expect_seq("rr_03", 2, 1'b1, 0, 3);
        // Full FIFO holds key 0 pending, then a repeat press overflows
        do_reset();
        evt_ready = 1'b0;
        for (int k = 0; k < NK; k++) begin
            key_raw = NK'(1) << k;
            tick(20);
            key_raw = '0;
            tick(20);
        end
        key_raw = 4'b0001;
        tick(20);
`ifndef KEY_SCHED_RELEASE_EN
        chk("full_valid", evt_valid, 1);
        chk("full_head", evt_id, 0);
        chk("full_ovf", overflow, 0);
`endif
        key_raw = '0;
        tick(20);
        key_raw = 4'b0001;
        tick(20);
        chk("repress_ovf", overflow, 1);
        evt_ready = 1'b1;
        tick(20);
`ifndef KEY_SCHED_RELEASE_EN
        expect_seq("drain", 5, 1'b0, 0, 1, 2, 3, 0);
        chk("drain_valid", evt_valid, 0);
`endif
        // Reset mid-stream with key 3 held through it
        evt_ready = 1'b0;
        key_raw = 4'b0110;
        tick(20);
        chk("queued_valid", evt_valid, 1);
        key_raw = 4'b1000;
        reset = 1'b0;
        #1;
        chk("midrst_valid", evt_valid, 0);
        chk("midrst_ovf", overflow, 0);
        chk("midrst_level", key_level, 0);
        tick(1);
        reset = 1'b1;
        got.delete();
        gotc.delete();
        for (int e = 1; e <= 14; e++) begin
            tick(1);
            if (e == 13) chk("held_e13", evt_valid, 0);
            if (e == 14) begin
                chk("held_e14", evt_valid, 1);
                chk("held_id", evt_id, 3);
            end
        end
        evt_ready = 1'b1;
        tick(20);
        expect_seq("held3", 1, 1'b0, 3);
        // Press then release of key 1
        key_raw = '0;
        do_reset();
        evt_ready = 1'b1;
        key_raw = 4'b0010;
        tick(20);
        key_raw = '0;
        tick(30);
`ifdef KEY_SCHED_RELEASE_EN
        expect_seq("rel", 2, 1'b0, 1, 9);
`else
        expect_seq("rel", 1, 1'b0, 1);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
